// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute control unit for the 16-bit datapath.
// Control outputs are registered from the next state, so each one is valid for the whole state it belongs to.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] read_data,
    output logic [1:0]  mem_cmd,
    output logic        addr_sel,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [1:0]  vsel,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        shift_ctrl,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        halted
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
        S_WIMM, S_GETA, S_GETB, S_EXEC, S_WREG, S_CMPS,
        S_ADR, S_LADR, S_MRD, S_MWB, S_SGETB, S_SDAT, S_MWR,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [1:0] mem_cmd;
        logic       addr_sel;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic [1:0] alu_op;
        logic [1:0] vsel;
        logic       write;
        logic       asel;
        logic       bsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       shift_ctrl;
        logic       halted;
    } ctl_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_ir;
    ctl_t        r_ctl;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];

    // Control word for a given state; IR fields are only consulted after UPC, when IR is settled.
    function automatic ctl_t decode(input state_t s, input logic [15:0] ir);
        ctl_t c;
        c = '0;
        c.mem_cmd = MNONE;
        case (s)
            S_RST: begin
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            S_IF1, S_IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MREAD;
            end
            S_UPC: c.load_pc = 1'b1;
            S_WIMM: begin
                c.vsel     = 2'b10;
                c.writenum = ir[10:8];
                c.write    = 1'b1;
            end
            S_GETA: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            S_GETB: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            S_EXEC: begin
                // MOV reg passes B through with A masked; ALU ops take their code from op.
                if (ir[15:13] == 3'b110) begin
                    c.asel   = 1'b1;
                    c.alu_op = 2'b00;
                end else begin
                    c.alu_op = ir[12:11];
                end
                c.loadc = 1'b1;
            end
            S_WREG: begin
                c.vsel     = 2'b00;
                c.writenum = ir[7:5];
                c.write    = 1'b1;
            end
            S_CMPS: begin
                c.alu_op = 2'b01;
                c.loads  = 1'b1;
            end
            S_ADR: begin
                c.bsel   = 1'b1;
                c.alu_op = 2'b00;
                c.loadc  = 1'b1;
            end
            S_LADR: c.load_addr = 1'b1;
            S_MRD: begin
                c.addr_sel = 1'b0;
                c.mem_cmd  = MREAD;
            end
            S_MWB: begin
                c.mem_cmd  = MREAD;
                c.vsel     = 2'b11;
                c.writenum = ir[7:5];
                c.write    = 1'b1;
            end
            S_SGETB: begin
                c.readnum = ir[7:5];
                c.loadb   = 1'b1;
            end
            S_SDAT: begin
                c.asel       = 1'b1;
                c.bsel       = 1'b0;
                c.alu_op     = 2'b00;
                c.shift_ctrl = 1'b1;
                c.loadc      = 1'b1;
            end
            S_MWR: begin
                c.addr_sel = 1'b0;
                c.mem_cmd  = MWRITE;
            end
            S_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RST:  w_state_next = S_IF1;
            S_IF1:  w_state_next = S_IF2;
            S_IF2:  w_state_next = S_UPC;
            S_UPC:  w_state_next = S_DEC;
            S_DEC: begin
                case ({w_opcode, w_op})
                    5'b110_10: w_state_next = S_WIMM;
                    5'b110_00: w_state_next = S_GETB;
                    5'b101_00,
                    5'b101_10,
                    5'b101_01: w_state_next = S_GETA;
                    5'b101_11: w_state_next = S_GETB;
                    5'b011_00,
                    5'b100_00: w_state_next = S_GETA;
                    default:   w_state_next = S_HALT;
                endcase
            end
            S_GETA: w_state_next = (w_opcode == 3'b101) ? S_GETB : S_ADR;
            S_GETB: w_state_next = (w_opcode == 3'b101 && w_op == 2'b01) ? S_CMPS : S_EXEC;
            S_EXEC: w_state_next = S_WREG;
            S_ADR:  w_state_next = S_LADR;
            S_LADR: w_state_next = (w_opcode == 3'b011) ? S_MRD : S_SGETB;
            S_MRD:  w_state_next = S_MWB;
            S_SGETB: w_state_next = S_SDAT;
            S_SDAT: w_state_next = S_MWR;
            S_WIMM, S_WREG, S_CMPS, S_MWB, S_MWR: w_state_next = S_IF1;
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST;
            r_ir    <= 16'h0000;
            r_ctl   <= decode(S_RST, 16'h0000);
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IF2) begin
                r_ir <= read_data;
            end
            r_ctl <= decode(w_state_next, r_ir);
        end
    end

    assign mem_cmd    = r_ctl.mem_cmd;
    assign addr_sel   = r_ctl.addr_sel;
    assign load_pc    = r_ctl.load_pc;
    assign reset_pc   = r_ctl.reset_pc;
    assign load_addr  = r_ctl.load_addr;
    assign writenum   = r_ctl.writenum;
    assign readnum    = r_ctl.readnum;
    assign ALUop      = r_ctl.alu_op;
    assign vsel       = r_ctl.vsel;
    assign write      = r_ctl.write;
    assign asel       = r_ctl.asel;
    assign bsel       = r_ctl.bsel;
    assign loada      = r_ctl.loada;
    assign loadb      = r_ctl.loadb;
    assign loadc      = r_ctl.loadc;
    assign loads      = r_ctl.loads;
    assign shift_ctrl = r_ctl.shift_ctrl;
    assign halted     = r_ctl.halted;

    assign shift  = r_ir[4:3];
    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class state by state against hand-computed control words.
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic [15:0] read_data;
    logic [1:0]  mem_cmd;
    logic        addr_sel, load_pc, reset_pc, load_addr;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop, vsel;
    logic        write, asel, bsel, loada, loadb, loadc, loads, shift_ctrl;
    logic [15:0] sximm8, sximm5;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    cpu_controller dut (
        .clk(clk), .reset(reset), .read_data(read_data),
        .mem_cmd(mem_cmd), .addr_sel(addr_sel), .load_pc(load_pc),
        .reset_pc(reset_pc), .load_addr(load_addr),
        .writenum(writenum), .readnum(readnum),
        .shift(shift), .ALUop(ALUop), .vsel(vsel),
        .write(write), .asel(asel), .bsel(bsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .shift_ctrl(shift_ctrl), .sximm8(sximm8), .sximm5(sximm5),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] obs_ctl;
    assign obs_ctl = {7'd0, mem_cmd, addr_sel, load_pc, reset_pc, load_addr,
                      writenum, readnum, ALUop, vsel, write, asel, bsel,
                      loada, loadb, loadc, loads, shift_ctrl, halted};

    function automatic logic [31:0] cv(
        input logic [1:0] mem, input logic as, input logic lpc, input logic rpc, input logic ladr,
        input logic [2:0] wn, input logic [2:0] rn, input logic [1:0] alu, input logic [1:0] vs,
        input logic wr, input logic asl, input logic bsl, input logic la, input logic lb,
        input logic lc, input logic ls, input logic sc, input logic hl);
        return {7'd0, mem, as, lpc, rpc, ladr, wn, rn, alu, vs, wr, asl, bsl, la, lb, lc, ls, sc, hl};
    endfunction

    logic [31:0] v_rst, v_if, v_upc, v_adr, v_ladr, v_cmps, v_sdat, v_mwr, v_mrd, v_halt;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] f_geta(input logic [2:0] rn);
        return cv(2'd0, 0, 0, 0, 0, 3'd0, rn, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [31:0] f_getb(input logic [2:0] rn);
        return cv(2'd0, 0, 0, 0, 0, 3'd0, rn, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [31:0] f_exec(input logic asl, input logic [1:0] alu);
        return cv(2'd0, 0, 0, 0, 0, 3'd0, 3'd0, alu, 2'd0, 0, asl, 0, 0, 0, 1, 0, 0, 0);
    endfunction
    function automatic logic [31:0] f_wreg(input logic [2:0] wn);
        return cv(2'd0, 0, 0, 0, 0, wn, 3'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [31:0] f_wimm(input logic [2:0] wn);
        return cv(2'd0, 0, 0, 0, 0, wn, 3'd0, 2'd0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [31:0] f_mwb(input logic [2:0] wn);
        return cv(2'b01, 0, 0, 0, 0, wn, 3'd0, 2'd0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Entered with the DUT sampled in IF1; leaves it sampled in the first instruction-specific state.
    task automatic fetch(input logic [15:0] instr);
        read_data = instr;
        chk("IF1", obs_ctl, v_if);
        step();
        chk("IF2", obs_ctl, v_if);
        step();
        chk("UPC", obs_ctl, v_upc);
        step();
        chk("DEC", obs_ctl, 32'd0);
        step();
    endtask

    initial begin
        v_rst  = cv(2'd0, 0, 1, 1, 0, 3'd0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_if   = cv(2'b01, 1, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_upc  = cv(2'd0, 0, 1, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_adr  = cv(2'd0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        v_ladr = cv(2'd0, 0, 0, 0, 1, 3'd0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_cmps = cv(2'd0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b01, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        v_sdat = cv(2'd0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
        v_mwr  = cv(2'b10, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_mrd  = cv(2'b01, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_halt = cv(2'd0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        reset = 1'b1;
        read_data = 16'h0000;
        step();
        step();
        chk("RST", obs_ctl, v_rst);
        chk("RST_ir", {16'd0, sximm8}, 32'd0);
        reset = 1'b0;
        step();
        $display("reset released");

        // MOV R0,#7
        fetch(16'hD007);
        chk("MOVI_WIMM", obs_ctl, f_wimm(3'd0));
        chk("MOVI_sx8", {16'd0, sximm8}, 32'h0007);
        step();
        $display("instr D007 MOV R0,#7");

        // MOV R1,#-2
        fetch(16'hD1FE);
        chk("MOVN_WIMM", obs_ctl, f_wimm(3'd1));
        chk("MOVN_sx8", {16'd0, sximm8}, 32'hFFFE);
        step();
        $display("instr D1FE MOV R1,#-2");

        // ADD R2,R1,R0 LSL1
        fetch(16'hA148);
        chk("ADD_GETA", obs_ctl, f_geta(3'd1));
        step();
        chk("ADD_GETB", obs_ctl, f_getb(3'd0));
        chk("ADD_shift", {30'd0, shift}, 32'd1);
        step();
        chk("ADD_EXEC", obs_ctl, f_exec(1'b0, 2'b00));
        step();
        chk("ADD_WREG", obs_ctl, f_wreg(3'd2));
        step();
        $display("instr A148 ADD R2,R1,R0,LSL#1");

        // CMP R1,R0
        fetch(16'hA900);
        chk("CMP_GETA", obs_ctl, f_geta(3'd1));
        step();
        chk("CMP_GETB", obs_ctl, f_getb(3'd0));
        step();
        chk("CMP_CMPS", obs_ctl, v_cmps);
        step();
        $display("instr A900 CMP R1,R0");

        // STR R3,[R1,#-1]
        fetch(16'h817F);
        chk("STR_sx5", {16'd0, sximm5}, 32'hFFFF);
        chk("STR_sx8", {16'd0, sximm8}, 32'h007F);
        chk("STR_GETA", obs_ctl, f_geta(3'd1));
        step();
        chk("STR_ADR", obs_ctl, v_adr);
        step();
        chk("STR_LADR", obs_ctl, v_ladr);
        step();
        chk("STR_SGETB", obs_ctl, f_getb(3'd3));
        step();
        chk("STR_SDAT", obs_ctl, v_sdat);
        step();
        chk("STR_MWR", obs_ctl, v_mwr);
        step();
        $display("instr 817F STR R3,[R1,#-1]");

        // LDR R2,[R1,#5]
        fetch(16'h6145);
        chk("LDR_sx5", {16'd0, sximm5}, 32'h0005);
        chk("LDR_GETA", obs_ctl, f_geta(3'd1));
        step();
        chk("LDR_ADR", obs_ctl, v_adr);
        step();
        chk("LDR_LADR", obs_ctl, v_ladr);
        step();
        chk("LDR_MRD", obs_ctl, v_mrd);
        step();
        chk("LDR_MWB", obs_ctl, f_mwb(3'd2));
        step();
        $display("instr 6145 LDR R2,[R1,#5]");

        // MVN R3,R2
        fetch(16'hB862);
        chk("MVN_GETB", obs_ctl, f_getb(3'd2));
        step();
        chk("MVN_EXEC", obs_ctl, f_exec(1'b0, 2'b11));
        step();
        chk("MVN_WREG", obs_ctl, f_wreg(3'd3));
        step();
        $display("instr B862 MVN R3,R2");

        // MOV R4,R5 LSR1
        fetch(16'hC095);
        chk("MOVR_GETB", obs_ctl, f_getb(3'd5));
        chk("MOVR_shift", {30'd0, shift}, 32'd2);
        step();
        chk("MOVR_EXEC", obs_ctl, f_exec(1'b1, 2'b00));
        step();
        chk("MOVR_WREG", obs_ctl, f_wreg(3'd4));
        step();
        $display("instr C095 MOV R4,R5,LSR#1");

        // ADD aborted by reset during GETA
        fetch(16'hA148);
        chk("ABT_GETA", obs_ctl, f_geta(3'd1));
        reset = 1'b1;
        step();
        chk("ABT_RST", obs_ctl, v_rst);
        chk("ABT_ir", {16'd0, sximm8}, 32'd0);
        reset = 1'b0;
        step();
        $display("instr A148 aborted by reset");

        // HALT, then memory returns 0x0000 which must not be fetched
        fetch(16'hE000);
        read_data = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            chk("HALT_hold", obs_ctl, v_halt);
            step();
        end
        $display("instr E000 HALT held 20 cycles");

        reset = 1'b1;
        step();
        chk("HRST", obs_ctl, v_rst);
        reset = 1'b0;
        step();

        // Illegal encoding 0x0000 falls into HALT
        fetch(16'h0000);
        chk("ILL_HALT", obs_ctl, v_halt);
        step();
        chk("ILL_HOLD", obs_ctl, v_halt);
        $display("instr 0000 illegal -> HALT");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
